// File: rtl/pi_nib_pkg.sv
// rtl/pi_nib_pkg.sv - shared types and helpers for the Pi nibble-bus link
package pi_nib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD_TA,
    ST_RD,
    ST_DONE
  } state_t;

  localparam int WR_BIT  = 3;
  localparam int IDX_MSB = 2;

  function automatic int nibs(input int data_w);
    return data_w / 4;
  endfunction

  // Counter must reach NIBS so the read path can see its closing edge.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w / 4 + 1);
  endfunction

endpackage

// File: rtl/pi_sync.sv
// rtl/pi_sync.sv - multi-flop synchroniser, cleared to zero on reset
module pi_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/pi_nib_link.sv
// rtl/pi_nib_link.sv - Pi nibble-bus register link with indexed rx/tx registers
module pi_nib_link
  import pi_nib_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_REG       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    r_clk,
  input  logic                    r_nibrst,
  input  logic [3:0]              nib_in,
  output logic [3:0]              nib_out,
  output logic                    nib_oe,
  input  logic [N_REG*DATA_W-1:0] tx_data,
  output logic [N_REG*DATA_W-1:0] rx_data,
  output logic                    rx_wr_stb,
  output logic                    tx_rd_stb,
  output logic [2:0]              xfer_idx,
  output logic                    err_stb
);

  localparam int NIBS = nibs(DATA_W);
  localparam int CW   = cnt_w(DATA_W);

  logic        rclk_s;
  logic        rclk_d;
  logic        nibrst_s;
  logic [3:0]  nib_s;
  logic        rise;

  pi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(reset), .d(r_clk), .q(rclk_s)
  );
  pi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_rst (
    .clk(clk), .rst(reset), .d(r_nibrst), .q(nibrst_s)
  );
  pi_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_nib (
    .clk(clk), .rst(reset), .d(nib_in), .q(nib_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rclk_d <= 1'b0;
    else       rclk_d <= rclk_s;
  end

  assign rise = rclk_s & ~rclk_d;

  state_t            state;
  state_t            nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] tx_sel;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rx_regs [N_REG];
  logic              cmd_wr;
  logic              cmd_ok;
  logic              last_nib;
  logic              rd_end;

  assign cmd_wr   = nib_s[WR_BIT];
  assign cmd_ok   = int'(nib_s[IDX_MSB:0]) < N_REG;
  assign last_nib = (cnt == CW'(NIBS - 1));
  assign rd_end   = (cnt == CW'(NIBS));
  assign wr_word  = {shreg[DATA_W-5:0], nib_s};

  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < N_REG; i++)
      if (nib_s[IDX_MSB:0] == 3'(i)) tx_sel = tx_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Synced nibrst wins over any coincident edge.
  always_comb begin
    nxt = state;
    if (nibrst_s) begin
      nxt = ST_CMD;
    end else if (rise) begin
      case (state)
        ST_CMD:   nxt = !cmd_ok ? ST_DONE : (cmd_wr ? ST_WR : ST_RD_TA);
        ST_WR:    nxt = last_nib ? ST_DONE : ST_WR;
        ST_RD_TA: nxt = ST_RD;
        ST_RD:    nxt = rd_end ? ST_DONE : ST_RD;
        default:  nxt = state;
      endcase
    end
  end

  logic act;
  logic do_cmd;
  logic do_err;
  logic do_snap;
  logic do_shift;
  logic do_commit;
  logic do_present;
  logic do_rd_end;

  always_comb begin
    act        = rise && !nibrst_s;
    do_cmd     = act && state == ST_CMD;
    do_err     = do_cmd && !cmd_ok;
    do_snap    = do_cmd && cmd_ok && !cmd_wr;
    do_shift   = act && state == ST_WR;
    do_commit  = do_shift && last_nib;
    do_present = act && (state == ST_RD_TA || (state == ST_RD && !rd_end));
    do_rd_end  = act && state == ST_RD && rd_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      shreg     <= '0;
      nib_out   <= '0;
      nib_oe    <= 1'b0;
      rx_wr_stb <= 1'b0;
      tx_rd_stb <= 1'b0;
      err_stb   <= 1'b0;
      xfer_idx  <= '0;
      for (int i = 0; i < N_REG; i++) rx_regs[i] <= '0;
    end else begin
      rx_wr_stb <= 1'b0;
      tx_rd_stb <= 1'b0;
      err_stb   <= do_err;
      if (nibrst_s) begin
        cnt     <= '0;
        nib_oe  <= 1'b0;
        nib_out <= '0;
      end
      if (do_cmd) begin
        xfer_idx <= nib_s[IDX_MSB:0];
        cnt      <= '0;
      end
      if (do_snap) shreg <= tx_sel;
      if (do_shift) begin
        shreg <= wr_word;
        cnt   <= cnt + 1'b1;
      end
      if (do_commit) begin
        rx_wr_stb <= 1'b1;
        for (int i = 0; i < N_REG; i++)
          if (xfer_idx == 3'(i)) rx_regs[i] <= wr_word;
      end
      if (do_present) begin
        nib_oe    <= 1'b1;
        nib_out   <= shreg[DATA_W-1 -: 4];
        shreg     <= shreg << 4;
        cnt       <= cnt + 1'b1;
        tx_rd_stb <= (cnt == CW'(NIBS - 1));
      end
      if (do_rd_end) begin
        nib_oe  <= 1'b0;
        nib_out <= '0;
      end
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_rx
    assign rx_data[g*DATA_W +: DATA_W] = rx_regs[g];
  end

endmodule

// File: tb/tb_pi_nib_link.sv
// tb/tb_pi_nib_link.sv - directed self-checking bench for pi_nib_link
`timescale 1ns/1ps
module tb_pi_nib_link;

  localparam int DATA_W = 16;
  localparam int N_REG  = 4;
  localparam int SS     = 2;

  logic                    clk = 0;
  logic                    reset = 0;
  logic                    r_clk = 0;
  logic                    r_nibrst = 0;
  logic [3:0]              nib_in = 0;
  logic [3:0]              nib_out;
  logic                    nib_oe;
  logic [N_REG*DATA_W-1:0] tx_data = '0;
  logic [N_REG*DATA_W-1:0] rx_data;
  logic                    rx_wr_stb;
  logic                    tx_rd_stb;
  logic [2:0]              xfer_idx;
  logic                    err_stb;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;

  pi_nib_link #(.DATA_W(DATA_W), .N_REG(N_REG), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .r_clk(r_clk), .r_nibrst(r_nibrst),
    .nib_in(nib_in), .nib_out(nib_out), .nib_oe(nib_oe),
    .tx_data(tx_data), .rx_data(rx_data), .rx_wr_stb(rx_wr_stb),
    .tx_rd_stb(tx_rd_stb), .xfer_idx(xfer_idx), .err_stb(err_stb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_wr_stb) wr_cnt <= wr_cnt + 1;
    if (tx_rd_stb) rd_cnt <= rd_cnt + 1;
    if (err_stb)   err_cnt <= err_cnt + 1;
    if (nib_oe)    oe_cnt <= oe_cnt + 1;
  end

  task automatic pi_edge(input logic [3:0] n);
    @(negedge clk);
    nib_in = n;
    r_clk  = 0;
    repeat (6) @(negedge clk);
    r_clk = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pi_nibrst();
    @(negedge clk);
    r_clk    = 0;
    r_nibrst = 1;
    repeat (6) @(negedge clk);
    r_nibrst = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (nib_oe !== 1'b0 || nib_out !== 4'h0) begin
      failures++; $display("FAIL reset_pins oe=%b out=%h want oe=0 out=0", nib_oe, nib_out);
    end
    checks++;
    if (rx_data !== '0 || xfer_idx !== 3'd0) begin
      failures++; $display("FAIL reset_regs rx=%h idx=%0d want 0/0", rx_data, xfer_idx);
    end
    checks++;
    if (rx_wr_stb !== 0 || tx_rd_stb !== 0 || err_stb !== 0) begin
      failures++; $display("FAIL reset_strobes wr=%b rd=%b err=%b want 0", rx_wr_stb, tx_rd_stb, err_stb);
    end
    // IDLE ignores edges until the first nibrst
    pi_edge(4'hA); pi_edge(4'h1); pi_edge(4'h2); pi_edge(4'h3); pi_edge(4'h4);
    checks++;
    if (rx_data !== '0 || wr_cnt !== 0) begin
      failures++; $display("FAIL idle_ignore rx=%h wr=%0d want 0/0", rx_data, wr_cnt);
    end
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    pi_nibrst();
    pi_edge(4'hA); pi_edge(4'h1); pi_edge(4'h2); pi_edge(4'h3);
    checks++;
    if (wr_cnt !== w0 || rx_data !== '0) begin
      failures++; $display("FAIL write_partial wr=%0d rx=%h want %0d/0", wr_cnt, rx_data, w0);
    end
    pi_edge(4'h4);
    checks++;
    if (rx_data !== 64'h0000_1234_0000_0000) begin
      failures++; $display("FAIL write_data rx=%h want 0000123400000000", rx_data);
    end
    checks++;
    if (wr_cnt !== w0 + 1 || xfer_idx !== 3'd2) begin
      failures++; $display("FAIL write_stb wr=%0d idx=%0d want %0d/2", wr_cnt - w0, xfer_idx, 1);
    end
    pi_edge(4'hF);
    checks++;
    if (rx_data !== 64'h0000_1234_0000_0000 || wr_cnt !== w0 + 1) begin
      failures++; $display("FAIL done_ignore rx=%h wr=%0d", rx_data, wr_cnt - w0);
    end
  endtask

  task automatic do_read(input logic [15:0] exp, input bit clobber);
    int r0;
    r0 = rd_cnt;
    tx_data[31:16] = 16'hBEEF;
    pi_nibrst();
    pi_edge(4'h1);
    if (clobber) tx_data[31:16] = 16'h0000;
    checks++;
    if (nib_oe !== 1'b0 || xfer_idx !== 3'd1) begin
      failures++; $display("FAIL read_cmd oe=%b idx=%0d want 0/1", nib_oe, xfer_idx);
    end
    for (int i = 0; i < 4; i++) begin
      pi_edge(4'h0);
      checks++;
      if (nib_oe !== 1'b1 || nib_out !== exp[15-4*i -: 4]) begin
        failures++; $display("FAIL read_nib%0d oe=%b out=%h want 1/%h", i, nib_oe, nib_out, exp[15-4*i -: 4]);
      end
      checks++;
      if (rd_cnt - r0 !== (i == 3 ? 1 : 0)) begin
        failures++; $display("FAIL read_stb%0d got=%0d want=%0d", i, rd_cnt - r0, (i == 3 ? 1 : 0));
      end
    end
    pi_edge(4'h0);
    checks++;
    if (nib_oe !== 1'b0 || rd_cnt - r0 !== 1) begin
      failures++; $display("FAIL read_end oe=%b rd=%0d want 0/1", nib_oe, rd_cnt - r0);
    end
  endtask

  task automatic test_read();
    do_read(16'hBEEF, 1'b0);
  endtask

  task automatic test_snapshot();
    do_read(16'hBEEF, 1'b1);
  endtask

  task automatic test_abort();
    int w0;
    w0 = wr_cnt;
    pi_nibrst();
    pi_edge(4'h9); pi_edge(4'h5); pi_edge(4'h6);
    pi_nibrst();
    checks++;
    if (rx_data !== 64'h0000_1234_0000_0000 || wr_cnt !== w0) begin
      failures++; $display("FAIL abort rx=%h wr=%0d want 0000123400000000/0", rx_data, wr_cnt - w0);
    end
  endtask

  task automatic test_invalid();
    int e0, w0, o0;
    e0 = err_cnt; w0 = wr_cnt;
    pi_nibrst();
    pi_edge(4'hE);
    checks++;
    if (err_cnt - e0 !== 1 || xfer_idx !== 3'd6) begin
      failures++; $display("FAIL inv_wr_err err=%0d idx=%0d want 1/6", err_cnt - e0, xfer_idx);
    end
    pi_edge(4'h7); pi_edge(4'h7); pi_edge(4'h7); pi_edge(4'h7);
    checks++;
    if (rx_data !== 64'h0000_1234_0000_0000 || wr_cnt !== w0 || err_cnt - e0 !== 1) begin
      failures++; $display("FAIL inv_wr_nochange rx=%h wr=%0d err=%0d", rx_data, wr_cnt - w0, err_cnt - e0);
    end
    o0 = oe_cnt;
    pi_nibrst();
    pi_edge(4'h6);
    for (int i = 0; i < 5; i++) pi_edge(4'h0);
    checks++;
    if (oe_cnt !== o0 || err_cnt - e0 !== 2) begin
      failures++; $display("FAIL inv_rd oe_cycles=%0d err=%0d want 0/2", oe_cnt - o0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_read();
    int o0;
    pi_nibrst();
    pi_edge(4'h1); pi_edge(4'h0); pi_edge(4'h0);
    checks++;
    if (nib_oe !== 1'b1) begin
      failures++; $display("FAIL midrd_pre oe=%b want 1", nib_oe);
    end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (nib_oe !== 1'b0 || rx_data !== '0) begin
      failures++; $display("FAIL async_reset oe=%b rx=%h want 0/0", nib_oe, rx_data);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    o0 = oe_cnt;
    for (int i = 0; i < 4; i++) pi_edge(4'h8);
    checks++;
    if (oe_cnt !== o0 || rx_data !== '0) begin
      failures++; $display("FAIL post_reset_ignore oe_cycles=%0d rx=%h want 0/0", oe_cnt - o0, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    pi_nibrst();
    pi_edge(4'h8); pi_edge(4'hC); pi_edge(4'hA); pi_edge(4'hF); pi_edge(4'hE);
    pi_nibrst();
    pi_edge(4'hB); pi_edge(4'h0); pi_edge(4'h0); pi_edge(4'h4); pi_edge(4'h2);
    checks++;
    if (rx_data !== 64'h0042_0000_0000_CAFE || xfer_idx !== 3'd3) begin
      failures++; $display("FAIL b2b rx=%h idx=%0d want 004200000000CAFE/3", rx_data, xfer_idx);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_snapshot();
    test_abort();
    test_invalid();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
